// File: rtl/core0_fetch_pkg.sv
// Shared definitions for the core0 fetch front end.
// Holds the opcode encodings, the immediate-length class enum and the helper
// that turns a length class into its immediate byte count.
package core0_fetch_pkg;

    // Opcode encodings. Any opcode not listed carries no immediate.
    localparam logic [7:0] I_NOP    = 8'h00;
    localparam logic [7:0] I_ADD    = 8'h01;
    localparam logic [7:0] I_SUB    = 8'h02;
    localparam logic [7:0] I_RET    = 8'h03;
    localparam logic [7:0] I_ADDI8  = 8'h10;
    localparam logic [7:0] I_BR8    = 8'h11;
    localparam logic [7:0] I_ADDI16 = 8'h20;
    localparam logic [7:0] I_JMP16  = 8'h21;
    localparam logic [7:0] I_CALL16 = 8'h22;
    localparam logic [7:0] I_LOOP16 = 8'h23;
    localparam logic [7:0] I_IMM32  = 8'h30;
    localparam logic [7:0] I_IMMW   = 8'h40;

    typedef enum logic [2:0] {
        LEN_IMM0,
        LEN_IMM8,
        LEN_IMM16,
        LEN_IMM32,
        LEN_WORD
    } len_class_e;

    // Immediate bytes following the opcode for a given length class.
    function automatic int unsigned imm_byte_count(input len_class_e cls,
                                                   input int unsigned word_bytes);
        case (cls)
            LEN_IMM8:  return 1;
            LEN_IMM16: return 2;
            LEN_IMM32: return 4;
            LEN_WORD:  return word_bytes;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/inst_length_decode.sv
// Combinational opcode -> immediate length class.
// Both instruction completeness and PC advance are derived from this one table.
// Ports:
//   opcode     in  8  opcode byte at queue head
//   len_class  out    immediate length class
module inst_length_decode
    import core0_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output len_class_e len_class
);

    always_comb begin
        len_class = LEN_IMM0;
        case (opcode)
            I_ADDI8, I_BR8:                       len_class = LEN_IMM8;
            I_ADDI16, I_JMP16, I_CALL16, I_LOOP16: len_class = LEN_IMM16;
            I_IMM32:                              len_class = LEN_IMM32;
            I_IMMW:                               len_class = LEN_WORD;
            default:                              len_class = LEN_IMM0;
        endcase
    end

endmodule

// File: rtl/inst_fetch.sv
// Front-end fetch stage of core0.
// Streams bytes from byte-wide synchronous program memory into a prefetch byte
// queue and presents one complete instruction (opcode + little-endian immediate)
// at a time with its PC and fall-through PC.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   pmem_req/pmem_addr         program memory read request and byte address
//   pmem_rdata                 read data, valid one cycle after the request
//   inst_valid/inst_ready      instruction handshake with decode
//   instruction/immediate      opcode byte and zero-extended immediate
//   inst_pc/inst_next_pc       opcode address and fall-through address
//   redirect/redirect_pc       flush the queue and restart fetch
module inst_fetch
    import core0_fetch_pkg::*;
#(
    parameter int unsigned WORD_WIDTH         = 32,
    parameter int unsigned PROGRAM_ADDR_WIDTH = 16,
    parameter int unsigned QUEUE_DEPTH        = 16,
    parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          pmem_req,
    output logic [PROGRAM_ADDR_WIDTH-1:0] pmem_addr,
    input  logic [7:0]                    pmem_rdata,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [7:0]                    instruction,
    output logic [WORD_WIDTH-1:0]         immediate,
    output logic [PROGRAM_ADDR_WIDTH-1:0] inst_pc,
    output logic [PROGRAM_ADDR_WIDTH-1:0] inst_next_pc,
    input  logic                          redirect,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] redirect_pc
);

    localparam int unsigned PAW        = PROGRAM_ADDR_WIDTH;
    localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
    localparam int unsigned QW         = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW         = QW + 1;

    logic [7:0]     queue_mem [QUEUE_DEPTH];
    logic [QW-1:0]  rd_ptr;
    logic [QW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [PAW-1:0] fetch_pc;
    logic [PAW-1:0] head_pc;
    logic           inflight;

    logic [7:0]     head_byte;
    len_class_e     head_class;
    logic [CW-1:0]  head_len;
    logic           push;
    logic           accept;

    assign head_byte = queue_mem[rd_ptr];

    inst_length_decode u_length_decode (
        .opcode    (head_byte),
        .len_class (head_class)
    );

    assign head_len = CW'(1 + imm_byte_count(head_class, WORD_BYTES));

    // Held low during reset so nothing is requested before the state is valid.
    assign pmem_req  = reset_n && !redirect &&
                       (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(QUEUE_DEPTH));
    assign pmem_addr = fetch_pc;
    assign push      = inflight;

    assign inst_valid = (count != '0) && (count >= head_len);
    assign accept     = inst_valid && inst_ready;

    always_comb begin
        instruction  = '0;
        immediate    = '0;
        inst_pc      = head_pc;
        inst_next_pc = head_pc;
        if (inst_valid) begin
            instruction  = head_byte;
            inst_next_pc = head_pc + PAW'(head_len);
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (i < imm_byte_count(head_class, WORD_BYTES)) begin
                    immediate[8*i +: 8] = queue_mem[rd_ptr + QW'(i + 1)];
                end
            end
        end
    end

    // No request is issued in a redirect cycle, so the only byte that can be
    // in flight at a redirect edge is the one returning in that same cycle.
    // Dropping it here and clearing inflight is the kill of the stale byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            head_pc  <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= pmem_req;
            if (pmem_req) begin
                fetch_pc <= fetch_pc + PAW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (accept) begin
                rd_ptr  <= rd_ptr + QW'(head_len);
                head_pc <= head_pc + PAW'(head_len);
            end
            count <= count + CW'(push) - (accept ? head_len : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            queue_mem[wr_ptr] <= pmem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch with a byte-wide synchronous memory model.
module tb_inst_fetch;
    import core0_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pmem_req;
    logic [15:0] pmem_addr;
    logic [7:0]  pmem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  instruction;
    logic [31:0] immediate;
    logic [15:0] inst_pc;
    logic [15:0] inst_next_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic [7:0]  mem [65536];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Synchronous program memory: data valid the cycle after the request.
    always @(posedge clk) pmem_rdata <= pmem_req ? mem[pmem_addr] : 8'hEE;

    inst_fetch #(
        .WORD_WIDTH         (32),
        .PROGRAM_ADDR_WIDTH (16),
        .QUEUE_DEPTH        (16),
        .RESET_PC           (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_req     (pmem_req),
        .pmem_addr    (pmem_addr),
        .pmem_rdata   (pmem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .instruction  (instruction),
        .immediate    (immediate),
        .inst_pc      (inst_pc),
        .inst_next_pc (inst_next_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!inst_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(inst_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h01;
        mem[16'h0000] = 8'hCD;     // unlisted opcode, length 1
        mem[16'h0001] = 8'hAB;
        mem[16'h0010] = 8'h30;     // I_IMM32
        mem[16'h0011] = 8'h78;
        mem[16'h0012] = 8'h56;
        mem[16'h0013] = 8'h34;
        mem[16'h0014] = 8'h12;
        for (int i = 0; i < 64; i++) mem[16'h0100 + i] = 8'(8'h80 + i);
        mem[16'h0200] = 8'h10;     // I_ADDI8
        mem[16'h0201] = 8'h5A;
        mem[16'hFFFF] = 8'h20;     // I_ADDI16 straddling the wrap

        reset_n     = 1'b0;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_req", 64'(pmem_req), 64'd0);
        check("rst_addr", 64'(pmem_addr), 64'h0000);
        check("rst_instr", 64'(instruction), 64'h00);
        check("rst_imm", 64'(immediate), 64'h0);
        check("rst_pc", 64'(inst_pc), 64'h0000);
        check("rst_next_pc", 64'(inst_next_pc), 64'h0000);

        // Straight-line stream of 1-byte ops
        reset_n = 1'b1;
        #1;
        check("c0_req", 64'(pmem_req), 64'd1);
        check("c0_addr", 64'(pmem_addr), 64'h0000);
        @(negedge clk);
        check("c1_valid", 64'(inst_valid), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("seq_valid", 64'(inst_valid), 64'd1);
            check("seq_pc", 64'(inst_pc), 64'(i));
            check("seq_next_pc", 64'(inst_next_pc), 64'(i + 1));
            check("seq_instr", 64'(instruction), 64'(mem[i]));
        end

        // 32-bit immediate at 0x10
        begin
            int n = 0;
            while (!(inst_valid && inst_pc == 16'h0010) && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("imm32_valid", 64'(inst_valid), 64'd1);
        check("imm32_pc", 64'(inst_pc), 64'h0010);
        check("imm32_instr", 64'(instruction), 64'h30);
        check("imm32_imm", 64'(immediate), 64'h12345678);
        check("imm32_next_pc", 64'(inst_next_pc), 64'h0015);
        @(negedge clk);
        check("after_imm32_valid", 64'(inst_valid), 64'd1);
        check("after_imm32_pc", 64'(inst_pc), 64'h0015);
        check("after_imm32_instr", 64'(instruction), 64'h01);

        // Redirect to 0x100 and stall long enough to fill the queue
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        check("redir_cycle_req", 64'(pmem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("redir_req", 64'(pmem_req), 64'd1);
        check("redir_addr", 64'(pmem_addr), 64'h0100);
        check("redir_valid", 64'(inst_valid), 64'd0);
        repeat (30) @(negedge clk);
        check("full_req", 64'(pmem_req), 64'd0);
        check("full_valid", 64'(inst_valid), 64'd1);
        check("full_pc", 64'(inst_pc), 64'h0100);
        check("full_instr", 64'(instruction), 64'h80);
        check("full_imm", 64'(immediate), 64'h0);
        check("full_next_pc", 64'(inst_next_pc), 64'h0101);
        inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("drain_valid", 64'(inst_valid), 64'd1);
            check("drain_pc", 64'(inst_pc), 64'(16'h0100 + i));
            check("drain_instr", 64'(instruction), 64'(8'h80 + i));
            @(negedge clk);
        end

        // Redirect while a byte is in flight
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        #1;
        check("redir2_cycle_req", 64'(pmem_req), 64'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("redir2_addr", 64'(pmem_addr), 64'h0200);
        check("redir2_req", 64'(pmem_req), 64'd1);
        wait_valid("redir2_wait", 10);
        check("redir2_pc", 64'(inst_pc), 64'h0200);
        check("redir2_instr", 64'(instruction), 64'h10);
        check("redir2_imm", 64'(immediate), 64'h5A);
        check("redir2_next_pc", 64'(inst_next_pc), 64'h0202);
        @(negedge clk);
        check("redir2_follow_pc", 64'(inst_pc), 64'h0202);

        // Instruction straddling the address wrap
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("wrap_wait", 10);
        check("wrap_pc", 64'(inst_pc), 64'hFFFF);
        check("wrap_instr", 64'(instruction), 64'h20);
        check("wrap_imm", 64'(immediate), 64'hABCD);
        check("wrap_next_pc", 64'(inst_next_pc), 64'h0002);
        @(negedge clk);
        check("wrap_follow_valid", 64'(inst_valid), 64'd1);
        check("wrap_follow_pc", 64'(inst_pc), 64'h0002);

        // Reset pulse mid-stream; the byte returning after release must be dropped
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(inst_valid), 64'd0);
        check("mid_rst_req", 64'(pmem_req), 64'd0);
        check("mid_rst_pc", 64'(inst_pc), 64'h0000);
        #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_addr", 64'(pmem_addr), 64'h0000);
        check("post_rst_valid", 64'(inst_valid), 64'd0);
        wait_valid("post_rst_wait", 6);
        check("post_rst_pc", 64'(inst_pc), 64'h0000);
        check("post_rst_instr", 64'(instruction), 64'hCD);
        check("post_rst_next_pc", 64'(inst_next_pc), 64'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
